// File: rtl/fpu_pkg.sv
// Shared FPU-side types and IEEE-754 single-precision classification helpers.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic        OP_ADD       = 1'b0;
  localparam logic        OP_MUL       = 1'b1;
  localparam logic [7:0]  EXP_ALL_ONES = 8'hFF;
  localparam logic [31:0] NAN_WORD     = 32'hFFFF_FFFF;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == EXP_ALL_ONES) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == EXP_ALL_ONES) && (x[22:0] == 23'd0);
  endfunction

  // Sign bit ignored: both +0 and -0 count as zero.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

endpackage

// File: rtl/fpu_special_detect.sv
// Flags operand combinations whose IEEE-754 result is a fixed NaN, so the
// arithmetic core never needs to see them.
module fpu_special_detect
  import fpu_pkg::*;
(
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        special
);

  logic w_any_nan;
  logic w_inf_sub;
  logic w_zero_inf;

  assign w_any_nan  = is_nan(a) | is_nan(b);
  // Only opposite-signed infinities cancel under addition.
  assign w_inf_sub  = (op == OP_ADD) & is_inf(a) & is_inf(b) & (a[31] ^ b[31]);
  assign w_zero_inf = (op == OP_MUL) &
                      ((is_zero(a) & is_inf(b)) | (is_inf(a) & is_zero(b)));
  assign special    = w_any_nan | w_inf_sub | w_zero_inf;

endmodule

// File: rtl/fpu_op_scheduler.sv
// Two-requester front end for one shared multi-cycle FP add/multiply core:
// round-robin grant, operand capture, special-case bypass, timeout abort.
module fpu_op_scheduler
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_exc,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_exc,
  output logic        core_start,
  output logic        core_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  input  logic        core_done,
  input  logic [31:0] core_result,
  output logic        busy,
  output state_t      dbg_state
);

  // Handshakes: a request transfers on a rising edge where reqN_valid and
  // reqN_ready are both high; a response transfers where rspN_valid and
  // rspN_ready are both high. Valid never depends on ready.

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last;
  logic        r_owner;
  logic        r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [15:0] r_cnt;
  logic [31:0] r_result;
  logic        r_exc;

  logic w_idle;
  logic w_grant0;
  logic w_grant1;
  logic w_accept;
  logic w_special;
  logic w_timeout;
  logic w_rsp_taken;

  // r_last holds the id served most recently; a tie goes to the other one.
  assign w_grant1    = req1_valid & (~req0_valid | ~r_last);
  assign w_grant0    = req0_valid & ~w_grant1;
  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle & (w_grant0 | w_grant1);
  assign w_timeout   = ((r_cnt + 16'd1) == TO_LAST);
  assign w_rsp_taken = r_owner ? rsp1_ready : rsp0_ready;

  fpu_special_detect u_special (
    .op      (r_op),
    .a       (r_a),
    .b       (r_b),
    .special (w_special)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = w_special ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (core_done || w_timeout) w_state_nxt = ST_RESP;
      ST_RESP:  if (w_rsp_taken) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_op     <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_cnt    <= 16'd0;
      r_result <= 32'd0;
      r_exc    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last  <= w_grant1;
        r_owner <= w_grant1;
        r_op    <= w_grant1 ? req1_op : req0_op;
        r_a     <= w_grant1 ? req1_a  : req0_a;
        r_b     <= w_grant1 ? req1_b  : req0_b;
      end
      if (r_state == ST_CHECK && w_special) begin
        r_result <= NAN_WORD;
        r_exc    <= 1'b1;
      end
      if (r_state == ST_ISSUE) r_cnt <= 16'd0;
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 16'd1;
        if (core_done) begin
          r_result <= core_result;
          r_exc    <= 1'b0;
        end else if (w_timeout) begin
          r_result <= NAN_WORD;
          r_exc    <= 1'b1;
        end
      end
    end
  end

  // rst_n gating keeps the readies low while reset is held with requests pending.
  assign req0_ready  = w_idle & rst_n & w_grant0;
  assign req1_ready  = w_idle & rst_n & w_grant1;
  assign rsp0_valid  = (r_state == ST_RESP) & ~r_owner;
  assign rsp1_valid  = (r_state == ST_RESP) &  r_owner;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_exc    = r_exc;
  assign rsp1_exc    = r_exc;
  assign core_start  = (r_state == ST_ISSUE);
  assign core_op     = r_op;
  assign core_a      = r_a;
  assign core_b      = r_b;
  assign busy        = ~w_idle;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Directed bench for fpu_op_scheduler: the bench plays the core and both
// requesters, with a queue of expected responses {owner, exc, result}.
module tb_fpu_op_scheduler;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic        req0_op = 1'b0, req1_op = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_exc, rsp1_exc;
  logic        core_start, core_op;
  logic [31:0] core_a, core_b;
  logic        core_done = 1'b0;
  logic [31:0] core_result = '0;
  logic        busy;
  state_t      dbg_state;

  fpu_op_scheduler #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_exc(rsp0_exc),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_exc(rsp1_exc),
    .core_start(core_start), .core_op(core_op),
    .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_result(core_result),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];
  logic        exp_last = 1'b1;

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] core_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
    return op ? (a ^ {b[15:0], b[31:16]}) : (a + b);
  endfunction

  function automatic logic [31:0] rand_normal();
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(1, 254));
    m = 23'($urandom);
    return {s, e, m};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_zero_check(input string tag);
    chk({tag, "_flags"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_exc,
                         rsp1_exc, core_start, core_op, busy}, 34'd0);
    chk({tag, "_core_a"}, core_a, 34'd0);
    chk({tag, "_core_b"}, core_b, 34'd0);
    chk({tag, "_rsp0_result"}, rsp0_result, 34'd0);
    chk({tag, "_rsp1_result"}, rsp1_result, 34'd0);
  endtask

  // Presents one request alone and returns in the CHECK cycle.
  task automatic send(input logic id, input logic op, input logic [31:0] a, input logic [31:0] b);
    int n;
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 20) begin tick(); n++; end
    chk("grant_single", {req1_ready, req0_ready}, id ? 34'd2 : 34'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_last = id;
    #1;
  endtask

  // From the CHECK cycle: verify launch, answer after lat cycles, return at RESP.
  task automatic core_path(input logic id, input logic op, input logic [31:0] a,
                           input logic [31:0] b, input int lat, input logic [31:0] res,
                           input string tag);
    chk({tag, "_no_start_in_check"}, core_start, 34'd0);
    tick();
    chk({tag, "_core_start"}, core_start, 34'd1);
    chk({tag, "_core_operands"}, {core_op, core_a}, {1'b0, op, a});
    chk({tag, "_core_b"}, core_b, b);
    chk({tag, "_no_ready_while_busy"}, {req1_ready, req0_ready}, 34'd0);
    repeat (lat) tick();
    core_done = 1'b1;
    core_result = res;
    #1;
    chk({tag, "_rsp_not_before_done"}, {rsp1_valid, rsp0_valid, core_start}, 34'd0);
    tick();
    core_done = 1'b0;
    core_result = 32'd0;
    #1;
    chk({tag, "_rsp_after_done"}, {rsp1_valid, rsp0_valid}, id ? 34'd2 : 34'd1);
  endtask

  task automatic take_rsp(input string tag);
    logic [33:0] exp;
    logic [33:0] obs;
    obs = rsp1_valid ? {1'b1, rsp1_exc, rsp1_result} : {1'b0, rsp0_exc, rsp0_result};
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s observed=%h expected=<no pending response>", tag, obs);
      return;
    end
    exp = exp_q.pop_front();
    chk({tag, "_owner_valid"}, {rsp1_valid, rsp0_valid}, exp[33] ? 34'd2 : 34'd1);
    chk({tag, "_payload"}, obs, exp);
    if (exp[33]) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    tick();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    #1;
    chk({tag, "_idle_after_take"}, {busy, rsp1_valid, rsp0_valid}, 34'd0);
  endtask

  task automatic special_case(input logic id, input logic op, input logic [31:0] a,
                              input logic [31:0] b, input string tag);
    exp_q.push_back({id, 1'b1, NAN_WORD});
    send(id, op, a, b);
    chk({tag, "_no_start_c1"}, core_start, 34'd0);
    tick();
    chk({tag, "_no_start_c2"}, core_start, 34'd0);
    chk({tag, "_rsp_c2"}, {rsp1_valid, rsp0_valid}, id ? 34'd2 : 34'd1);
    take_rsp(tag);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] ca[2][5];
  logic [31:0] cb[2][5];
  int          idx[2];

  initial begin
    logic        g;
    logic [31:0] a, b, res;
    int          lat;

    // Reset with a request pending: everything must stay at zero.
    req0_valid = 1'b1; req0_a = 32'h3F80_0000;
    #2;
    reset_zero_check("reset");
    tick();
    chk("reset_state", dbg_state, ST_IDLE);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single add with a 4-cycle core.
    exp_q.push_back({1'b0, 1'b0, 32'h4040_0000});
    send(1'b0, OP_ADD, 32'h3F80_0000, 32'h4000_0000);
    core_path(1'b0, OP_ADD, 32'h3F80_0000, 32'h4000_0000, 4, 32'h4040_0000, "add1");
    take_rsp("add1");

    // Special cases bypass the core.
    special_case(1'b0, OP_ADD, 32'h7FC0_0000, 32'h3F80_0000, "nan");
    special_case(1'b1, OP_ADD, 32'h7F80_0000, 32'hFF80_0000, "inf_minus_inf");
    special_case(1'b0, OP_MUL, 32'h0000_0000, 32'h7F80_0000, "zero_times_inf");
    special_case(1'b1, OP_MUL, 32'hFF80_0000, 32'h8000_0000, "inf_times_zero");

    // Near-special operand pairs that must still use the core.
    exp_q.push_back({1'b0, 1'b0, 32'h7F80_0000});
    send(1'b0, OP_ADD, 32'h7F80_0000, 32'h7F80_0000);
    core_path(1'b0, OP_ADD, 32'h7F80_0000, 32'h7F80_0000, 2, 32'h7F80_0000, "inf_plus_inf");
    take_rsp("inf_plus_inf");
    exp_q.push_back({1'b1, 1'b0, 32'h8000_0000});
    send(1'b1, OP_MUL, 32'h8000_0000, 32'h3F80_0000);
    core_path(1'b1, OP_MUL, 32'h8000_0000, 32'h3F80_0000, 1, 32'h8000_0000, "negzero_mul");
    take_rsp("negzero_mul");

    // Contention: both requesters hold five multiplies each.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 5; i++) begin
        ca[r][i] = rand_normal();
        cb[r][i] = rand_normal();
      end
    idx[0] = 0;
    idx[1] = 0;
    for (int t = 0; t < 10; t++) begin
      req0_valid = (idx[0] < 5); req0_op = OP_MUL;
      req1_valid = (idx[1] < 5); req1_op = OP_MUL;
      if (idx[0] < 5) begin req0_a = ca[0][idx[0]]; req0_b = cb[0][idx[0]]; end
      if (idx[1] < 5) begin req1_a = ca[1][idx[1]]; req1_b = cb[1][idx[1]]; end
      #1;
      g = (req0_valid && req1_valid) ? ~exp_last : req1_valid;
      chk("arb_grant", {req1_ready, req0_ready}, g ? 34'd2 : 34'd1);
      a = ca[g][idx[g]];
      b = cb[g][idx[g]];
      res = core_fn(OP_MUL, a, b);
      exp_q.push_back({g, 1'b0, res});
      tick();
      exp_last = g;
      idx[g]++;
      lat = $urandom_range(1, 5);
      core_path(g, OP_MUL, a, b, lat, res, "contend");
      take_rsp("contend");
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;

    // Timeout: the core never answers; a late done must be ignored.
    exp_q.push_back({1'b0, 1'b1, NAN_WORD});
    send(1'b0, OP_ADD, 32'h3F80_0000, 32'h3F80_0000);
    tick();
    chk("timeout_start", core_start, 34'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("timeout_waiting", {rsp1_valid, rsp0_valid}, 34'd0);
    end
    tick();
    chk("timeout_rsp_at_8", {rsp1_valid, rsp0_valid}, 34'd1);
    core_done = 1'b1;
    core_result = 32'h1234_5678;
    #1;
    take_rsp("timeout");
    core_done = 1'b0;
    core_result = 32'd0;
    tick();
    chk("late_done_ignored", {busy, rsp1_valid, rsp0_valid}, 34'd0);

    // Backpressure: response held, competing request not accepted.
    exp_q.push_back({1'b1, 1'b1, NAN_WORD});
    send(1'b1, OP_ADD, 32'h7FC0_0000, 32'h3F80_0000);
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {rsp1_valid, rsp1_exc, rsp1_result}, {2'b11, NAN_WORD});
      chk("bp_no_accept", {req1_ready, req0_ready}, 34'd0);
      tick();
    end
    req0_valid = 1'b0;
    #1;
    take_rsp("backpressure");

    // Reset during WAIT drops the transaction.
    send(1'b0, OP_MUL, 32'h3FC0_0000, 32'h4000_0000);
    tick();
    tick();
    chk("pre_reset_wait", dbg_state, ST_WAIT);
    req0_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    reset_zero_check("mid_reset");
    tick();
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b1;
    exp_last = 1'b1;
    tick();
    chk("post_reset_idle", {busy, dbg_state}, 34'd0);
    exp_q.push_back({1'b0, 1'b0, 32'h4040_0000});
    send(1'b0, OP_MUL, 32'h3FC0_0000, 32'h4000_0000);
    core_path(1'b0, OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 3, 32'h4040_0000, "post_reset");
    take_rsp("post_reset");

    chk("queue_drained", exp_q.size(), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
